// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage load/store request/response bus between pipeline and data memory.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle byte/half/word data memory serving one outstanding MEM-stage request.
// Define DMEM_ERR_EN to flag misaligned/out-of-range accesses instead of aligning and wrapping.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic                  clk,
    input logic                  rst,
    data_mem_responder_if.slave  bus
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0]   mem [DEPTH_WORDS];
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          ready_q, resp_valid_q, resp_err_q, pend_err_q;
    logic [31:0]   resp_rdata_q, pend_rdata_q;
    logic          accept, err_d;
    logic [1:0]    off;
    logic [3:0]    be;
    logic [IW-1:0] idx;
    logic [31:0]   wdata_sh, shifted, rdata_d;

    assign accept = bus.req_valid & ready_q;
    assign idx    = bus.req_addr[IW+1:2];

`ifdef DMEM_ERR_EN
    assign err_d = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size[1] && |bus.req_addr[1:0]) ||
                   ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:IW+2];
    assign err_d = 1'b0;
`endif

    // Misaligned low bits are dropped here, so the no-error build aligns for free.
    always_comb begin
        off      = bus.req_size == 2'b00 ? bus.req_addr[1:0] :
                   bus.req_size == 2'b01 ? {bus.req_addr[1], 1'b0} : 2'b00;
        be       = bus.req_size == 2'b00 ? 4'b0001 << off :
                   bus.req_size == 2'b01 ? 4'b0011 << off : 4'b1111;
        wdata_sh = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                   bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
        shifted  = mem[idx] >> {off, 3'b000};
        rdata_d  = (err_d || bus.req_write) ? 32'h0 :
                   bus.req_size == 2'b00 ? {{24{bus.req_signed & shifted[7]}}, shifted[7:0]} :
                   bus.req_size == 2'b01 ? {{16{bus.req_signed & shifted[15]}}, shifted[15:0]} :
                   shifted;
    end

    always_ff @(posedge clk) begin
        if (rst && accept && bus.req_write && !err_d)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            pend_rdata_q <= 32'h0;
            pend_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (accept) begin
                state_q      <= WAIT;
                cnt_q        <= CW'(LATENCY);
                ready_q      <= 1'b0;
                pend_rdata_q <= rdata_d;
                pend_err_q   <= err_d;
            end else if (state_q == RESP) begin
                state_q <= IDLE;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_q      <= RESP;
                    ready_q      <= 1'b1;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= pend_rdata_q;
                    resp_err_q   <= pend_err_q;
                end
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule
